// File: rtl/arb_mux_pkg.sv
// Shared constants for the arbitrated, registered channel selector.
package arb_mux_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PRIO   = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational fixed-priority / round-robin grant finder; zero latency, no state.
// Mode 11 falls through to fixed priority, i.e. a search starting at channel 0.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 7,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [SELW-1:0] i_ptr,
  input  logic [1:0]      i_mode,
  output logic [SELW-1:0] o_gnt,
  output logic            o_gnt_vld
);

  logic [SELW-1:0] w_start;
  logic [SELW:0]   w_sum;
  logic [SELW:0]   w_idx;

  assign w_start = (i_mode == MODE_RR) ? i_ptr : '0;

  // Walk from the farthest offset back to the start so the nearest request wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_vld = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_start} + (SELW + 1)'(k);
      w_idx = (w_sum >= (SELW + 1)'(NCH)) ? (w_sum - (SELW + 1)'(NCH)) : w_sum;
      if (i_req[w_idx[SELW-1:0]]) begin
        o_gnt     = w_idx[SELW-1:0];
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// Selects one of NCH channels into a one-entry output register; 1-cycle latency.
// Full-rate pass-through: a new load is accepted whenever the register is empty or draining.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 7,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 err_sel
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic [SELW-1:0]  r_rr_ptr;
  logic             r_err_sel;

  logic             w_load_en;
  logic             w_sel_ok;
  logic             w_dir_vld;
  logic [SELW-1:0]  w_arb_gnt;
  logic             w_arb_vld;
  logic [SELW-1:0]  w_gnt;
  logic             w_gnt_vld;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_sel_ok  = ({1'b0, sel} < (SELW + 1)'(NCH));

  always_comb begin
    w_dir_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        w_dir_vld = 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .i_req     (in_valid),
    .i_ptr     (r_rr_ptr),
    .i_mode    (mode),
    .o_gnt     (w_arb_gnt),
    .o_gnt_vld (w_arb_vld)
  );

  assign w_gnt     = (mode == MODE_DIRECT) ? sel       : w_arb_gnt;
  assign w_gnt_vld = (mode == MODE_DIRECT) ? w_dir_vld : w_arb_vld;
  assign w_xfer    = w_load_en && w_gnt_vld;

  // Ready is forced low during reset so no source believes it was accepted.
  always_comb begin
    in_ready = '0;
    w_data   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt == SELW'(i)) begin
        in_ready[i] = w_xfer && !rst;
        w_data      = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_data;
        r_out_chan <= w_gnt;
        if (mode == MODE_RR) begin
          r_rr_ptr <= (w_gnt == SELW'(NCH - 1)) ? '0 : (w_gnt + SELW'(1));
        end
      end
    end
  end

  // Set wins over clear so an error coincident with err_clr is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sel <= 1'b0;
    end else if ((mode == MODE_DIRECT) && !w_sel_ok && w_load_en) begin
      r_err_sel <= 1'b1;
    end else if (err_clr) begin
      r_err_sel <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign err_sel   = r_err_sel;

endmodule

// File: doc/arb_mux_reg.md
Name: arb_mux_reg

Overview:
- Parametrised successor to the fixed 7-input, 32-bit combinational selector.
- Selects one of NCH WIDTH-bit source channels into a single registered output with valid/ready handshaking.
- Three selection modes: direct select, fixed priority, round-robin.
- Used in the datapath wherever several producers share one consumer, e.g. write-back source or bus-master selection. Replaces the undriven (high-Z) output on an illegal select with a sticky error flag.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NCH, 7, number of input channels (2..16).
- SELW, $clog2(NCH), width of sel and out_chan.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 direct, 01 fixed priority, 10 round-robin, 11 behaves as 01.
- sel  in  SELW  channel index, used in direct mode only.
- in_valid  in  NCH  per-channel data valid.
- in_data  in  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  per-channel accept, at most one bit set.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SELW  index of the channel that out_data came from.
- out_ready  in  1  consumer accepts out_data.
- err_clr  in  1  clears err_sel.
- err_sel  out  1  sticky: direct-mode sel >= NCH was seen while a load was possible.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_chan=0, err_sel=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready=0 while rst is high.
- load_en = !out_valid || out_ready. This gives one-entry pass-through: back-to-back transfers at full rate, no bubble.
- Grant (combinational, from this cycle's inputs):
  - Direct: grant = sel if sel < NCH and in_valid[sel]; otherwise no grant.
  - Fixed priority: grant = lowest index i with in_valid[i].
  - Round-robin: grant = first i with in_valid[i], searching from rr_ptr upward and wrapping at NCH-1 -> 0.
- in_ready[g] = load_en && grant exists && g == grant. All other bits are 0.
- Transfer at a rising edge when in_valid[g] && in_ready[g]:
  - out_data <= channel g's data.
  - out_chan <= g.
  - out_valid <= 1.
- Latency: exactly 1 cycle from input handshake to out_valid.
- If out_ready=1, out_valid=1 and there is no grant: out_valid <= 0 next cycle. out_data and out_chan keep their last values.
- Stall: while out_valid && !out_ready, out_data and out_chan are held stable and all in_ready bits are 0.
- rr_ptr updates only on a transfer made in round-robin mode: rr_ptr <= (g == NCH-1) ? 0 : g+1. In other modes rr_ptr is held.
- err_sel:
  - Set when mode is direct, sel >= NCH and load_en=1.
  - Cleared when err_clr=1. Set has priority over clear in the same cycle.
  - When NCH is a power of two this condition can never occur.
- Mode or sel changes take effect on the next grant evaluation. Data already captured is never altered.
- Reset asserted mid-stall: the held data is discarded and out_valid drops immediately (asynchronous).
- Sources are required to keep in_valid and in_data stable until accepted. The block does not check this.

Decomposition:
- Package arb_mux_pkg holds the mode constants MODE_DIRECT=2'b00, MODE_PRIO=2'b01, MODE_RR=2'b10.
- One sub-module: rr_arbiter (NCH parameter).
  - Inputs: request vector, rr_ptr, mode.
  - Outputs: grant index and grant-valid.
  - Purely combinational.
- Output register, rr_ptr and err_sel stay in the top level.

Test Plan:
- Reset: with rst=1, all outputs read 0. Release rst, hold in_valid=0 for 5 cycles -> out_valid stays 0 and rr_ptr stays 0.
- Direct mode, sel=3, in_valid=7'b0001000, ch3 data=32'hDEADBEEF, out_ready=1 -> in_ready=7'b0001000. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_chan=3.
- Direct mode, sel=7 (NCH=7), all in_valid=1 -> in_ready=0, err_sel=1 on the next cycle and stays 1. Pulse err_clr with sel=0 -> err_sel returns to 0.
- Fixed priority: in_valid=7'b0110100 for 3 cycles, out_ready=1 -> out_chan=2 on every transfer.
- Round-robin: all 7 channels valid, out_ready=1 for 9 cycles -> out_chan sequence 0,1,2,3,4,5,6,0,1.
- Backpressure: out_ready=0 after the first transfer of ch5=32'h12345678 -> out_data, out_chan=5 and out_valid held, all in_ready=0. Raise out_ready -> the next channel is loaded in that same edge with no bubble.
